// File: rtl/master_bus_bridge.sv
// Initiator end of the bit-serial system bus: serializes address and write data
// MSB first on wr_bus, deserializes read data from rd_bus, and reports timeouts.
module master_bus_bridge #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  // front-end request/response
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_mode,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  // serial bus
  output logic                  mode,
  output logic                  wr_bus,
  output logic                  master_valid,
  output logic                  master_ready,
  input  logic                  slave_ready,
  input  logic                  slave_valid,
  input  logic                  rd_bus,
  input  logic                  split,
  output logic                  split_seen,
  // debug view of the FSM state
  output logic [2:0]            state_dbg_o
);

  localparam int MAXW       = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW         = $clog2(MAXW + 1);
  localparam int TW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TMO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TMO_LAST_I);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_RDATA = 3'd3,
    S_SPLIT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_sh_q, addr_sh_d;
  logic [DATA_WIDTH-1:0] wdata_sh_q, wdata_sh_d;
  logic [DATA_WIDTH-1:0] rdata_sh_q, rdata_sh_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  mode_q, mode_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  split_seen_q, split_seen_d;

  logic                  tmo_hit;
  logic [DATA_WIDTH-1:0] rdata_shifted;

  // The stall that brings the counter up to TIMEOUT is the one that aborts.
  assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TMO_LAST);

  always_comb begin
    rdata_shifted    = rdata_sh_q << 1;
    rdata_shifted[0] = rd_bus;
  end

  always_comb begin
    state_d      = state_q;
    addr_sh_d    = addr_sh_q;
    wdata_sh_d   = wdata_sh_q;
    rdata_sh_d   = rdata_sh_q;
    rsp_rdata_d  = rsp_rdata_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    mode_d       = mode_q;
    rsp_err_d    = rsp_err_q;
    split_seen_d = split_seen_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_sh_d    = req_addr;
          wdata_sh_d   = req_wdata;
          rdata_sh_d   = '0;
          mode_d       = req_mode;
          rsp_rdata_d  = '0;
          rsp_err_d    = 1'b0;
          split_seen_d = 1'b0;
          cnt_d        = '0;
          tmo_d        = '0;
          state_d      = S_ADDR;
        end
      end

      S_ADDR: begin
        if (slave_ready) begin
          addr_sh_d = addr_sh_q << 1;
          tmo_d     = '0;
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            state_d = mode_q ? S_WDATA : S_RDATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (tmo_hit) begin
          cnt_d       = '0;
          tmo_d       = '0;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = S_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_WDATA: begin
        if (slave_ready) begin
          wdata_sh_d = wdata_sh_q << 1;
          tmo_d      = '0;
          if (cnt_q == DATA_LAST) begin
            cnt_d       = '0;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
            state_d     = S_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (tmo_hit) begin
          cnt_d       = '0;
          tmo_d       = '0;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = S_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      // A bit arriving in the same cycle as split wins; split only parks
      // the transfer before the first read bit.
      S_RDATA: begin
        if (slave_valid) begin
          rdata_sh_d = rdata_shifted;
          tmo_d      = '0;
          if (cnt_q == DATA_LAST) begin
            cnt_d       = '0;
            rsp_rdata_d = rdata_shifted;
            rsp_err_d   = 1'b0;
            state_d     = S_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (split && (cnt_q == '0)) begin
          split_seen_d = 1'b1;
          state_d      = S_SPLIT;
        end else if (tmo_hit) begin
          cnt_d       = '0;
          tmo_d       = '0;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = S_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      // Timeout is suspended while the slave holds the read split.
      S_SPLIT: begin
        if (slave_valid) begin
          rdata_sh_d = rdata_shifted;
          tmo_d      = '0;
          if (cnt_q == DATA_LAST) begin
            cnt_d       = '0;
            rsp_rdata_d = rdata_shifted;
            rsp_err_d   = 1'b0;
            state_d     = S_DONE;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = S_RDATA;
          end
        end
      end

      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_sh_q    <= '0;
      wdata_sh_q   <= '0;
      rdata_sh_q   <= '0;
      rsp_rdata_q  <= '0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      mode_q       <= 1'b0;
      rsp_err_q    <= 1'b0;
      split_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_sh_q    <= addr_sh_d;
      wdata_sh_q   <= wdata_sh_d;
      rdata_sh_q   <= rdata_sh_d;
      rsp_rdata_q  <= rsp_rdata_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      mode_q       <= mode_d;
      rsp_err_q    <= rsp_err_d;
      split_seen_q <= split_seen_d;
    end
  end

  // Outputs decode from registered state only, so none depends on an input.
  always_comb begin
    req_ready    = (state_q == S_IDLE);
    rsp_valid    = (state_q == S_DONE);
    master_valid = (state_q == S_ADDR) || (state_q == S_WDATA);
    master_ready = (state_q == S_RDATA) || (state_q == S_SPLIT);
    wr_bus       = 1'b0;
    if (state_q == S_ADDR) begin
      wr_bus = addr_sh_q[ADDR_WIDTH-1];
    end else if (state_q == S_WDATA) begin
      wr_bus = wdata_sh_q[DATA_WIDTH-1];
    end
  end

  assign mode        = mode_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign split_seen  = split_seen_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_master_bus_bridge.sv
// Directed bench for master_bus_bridge: write, read, split, timeout, held
// response and mid-transfer reset, against hand-computed expectations.
module tb_master_bus_bridge;

  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_mode;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          mode;
  logic          wr_bus;
  logic          master_valid;
  logic          master_ready;
  logic          slave_ready;
  logic          slave_valid;
  logic          rd_bus;
  logic          split;
  logic          split_seen;
  logic [2:0]    state_dbg;

  int n_cmp;
  int n_err;

  master_bus_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_mode     (req_mode),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mode         (mode),
    .wr_bus       (wr_bus),
    .master_valid (master_valid),
    .master_ready (master_ready),
    .slave_ready  (slave_ready),
    .slave_valid  (slave_valid),
    .rd_bus       (rd_bus),
    .split        (split),
    .split_seen   (split_seen),
    .state_dbg_o  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks; every task starts and ends on a falling edge
  task automatic send_req(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] d);
    check_eq("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_mode  = m;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("mv_start", {31'd0, master_valid}, 32'd1);
    check_eq("mode_start", {31'd0, mode}, {31'd0, m});
  endtask

  // Slave idles one cycle, then accepts nbits consecutively.
  task automatic slave_accept(input int nbits, output logic [31:0] bits,
                              output logic mv_ok, output logic mode_ok, input logic m);
    slave_ready = 1'b0;
    @(negedge clk);
    slave_ready = 1'b1;
    bits    = '0;
    mv_ok   = 1'b1;
    mode_ok = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      mv_ok   = mv_ok & master_valid;
      mode_ok = mode_ok & (mode == m);
      bits    = {bits[30:0], wr_bus};
      @(negedge clk);
    end
    slave_ready = 1'b0;
  endtask

  task automatic drive_rd(input logic [DW-1:0] d, output logic mr_ok);
    mr_ok       = 1'b1;
    slave_valid = 1'b1;
    for (int i = DW - 1; i >= 0; i--) begin
      mr_ok  = mr_ok & master_ready & ~master_valid;
      rd_bus = d[i];
      @(negedge clk);
    end
    slave_valid = 1'b0;
    rd_bus      = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("rsp_drop", {31'd0, rsp_valid}, 32'd0);
    check_eq("req_ready_back", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
    logic [31:0] bits;
    logic        mv_ok, mode_ok;
    send_req(1'b1, a, d);
    slave_accept(AW + DW, bits, mv_ok, mode_ok, 1'b1);
    check_eq({tag, "_bits"}, bits, {8'd0, a, d});
    check_eq({tag, "_mv_hi"}, {31'd0, mv_ok}, 32'd1);
    check_eq({tag, "_mode"}, {31'd0, mode_ok}, 32'd1);
    check_eq({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check_eq({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    check_eq({tag, "_rsp_rdata"}, {24'd0, rsp_rdata}, 32'd0);
    check_eq({tag, "_mv_done"}, {31'd0, master_valid}, 32'd0);
  endtask

  // scoreboard: expected read words, popped as responses complete
  logic [DW-1:0] exp_q[$];

  initial begin
    logic [31:0] bits;
    logic        mv_ok, mode_ok, mr_ok, hold_ok;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    req_valid = 1'b0; req_mode = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; slave_ready = 1'b0; slave_valid = 1'b0;
    rd_bus = 1'b0; split = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset state
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_outputs", {24'd0, rsp_valid, rsp_err, mode, wr_bus,
                             master_valid, master_ready, split_seen, 1'b0}, 32'd0);
    check_eq("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
    check_eq("rst_state", {29'd0, state_dbg}, 32'd0);

    // write 0x1234 / 0xA5
    do_write(16'h1234, 8'hA5, "wr1");
    finish_rsp();

    // read 0x00F0, data 0x3C after three stall cycles
    exp_q.push_back(8'h3C);
    send_req(1'b0, 16'h00F0, 8'hFF);
    slave_accept(AW, bits, mv_ok, mode_ok, 1'b0);
    check_eq("rd1_addr_bits", bits, 32'h0000_00F0);
    check_eq("rd1_mode", {31'd0, mode_ok}, 32'd1);
    repeat (3) begin
      check_eq("rd1_stall_mv_mr", {30'd0, master_valid, master_ready}, 32'd1);
      @(negedge clk);
    end
    drive_rd(8'h3C, mr_ok);
    check_eq("rd1_mr_during", {31'd0, mr_ok}, 32'd1);
    check_eq("rd1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("rd1_rdata", {24'd0, rsp_rdata}, {24'd0, exp_q.pop_front()});
    check_eq("rd1_split_err", {30'd0, split_seen, rsp_err}, 32'd0);
    check_eq("rd1_mr_done", {31'd0, master_ready}, 32'd0);
    finish_rsp();

    // split read: 40 cycles of split, longer than the timeout
    exp_q.push_back(8'h81);
    send_req(1'b0, 16'h0ABC, 8'h00);
    slave_accept(AW, bits, mv_ok, mode_ok, 1'b0);
    check_eq("rd2_addr_bits", bits, 32'h0000_0ABC);
    split = 1'b1;
    repeat (40) @(negedge clk);
    split = 1'b0;
    check_eq("rd2_split_seen", {31'd0, split_seen}, 32'd1);
    check_eq("rd2_no_tmo", {31'd0, rsp_valid}, 32'd0);
    check_eq("rd2_mr_split", {31'd0, master_ready}, 32'd1);
    drive_rd(8'h81, mr_ok);
    check_eq("rd2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("rd2_rdata", {24'd0, rsp_rdata}, {24'd0, exp_q.pop_front()});
    check_eq("rd2_err", {31'd0, rsp_err}, 32'd0);
    check_eq("rd2_split_sticky", {31'd0, split_seen}, 32'd1);
    finish_rsp();

    // timeout: slave stops after 5 address bits
    send_req(1'b1, 16'hC3C3, 8'h5A);
    slave_ready = 1'b0;
    @(negedge clk);
    slave_ready = 1'b1;
    repeat (5) @(negedge clk);
    slave_ready = 1'b0;
    repeat (15) @(negedge clk);
    check_eq("tmo_before", {30'd0, rsp_valid, master_valid}, 32'd1);
    @(negedge clk);
    check_eq("tmo_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("tmo_err", {31'd0, rsp_err}, 32'd1);
    check_eq("tmo_mv", {31'd0, master_valid}, 32'd0);
    check_eq("tmo_rdata", {24'd0, rsp_rdata}, 32'd0);
    finish_rsp();

    // response held in DONE; a request pulse meanwhile is ignored
    do_write(16'h5A5A, 8'h0F, "wr2");
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      hold_ok   = hold_ok & rsp_valid & ~req_ready & ~master_valid;
      req_valid = (i == 4);
      req_mode  = 1'b0;
      req_addr  = 16'hDEAD;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check_eq("hold_ok", {31'd0, hold_ok}, 32'd1);
    finish_rsp();
    @(negedge clk);
    check_eq("hold_no_new_req", {30'd0, master_valid, req_ready}, 32'd1);

    // reset during address bit 7
    send_req(1'b1, 16'hFFFF, 8'h11);
    slave_ready = 1'b0;
    @(negedge clk);
    slave_ready = 1'b1;
    repeat (7) @(negedge clk);
    slave_ready = 1'b0;
    check_eq("prerst_busy", {29'd0, mode, wr_bus, master_valid}, 32'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_outputs", {24'd0, rsp_valid, rsp_err, mode, wr_bus,
                                master_valid, master_ready, split_seen, 1'b0}, 32'd0);
    check_eq("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    check_eq("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    do_write(16'hBEEF, 8'h3C, "wr3");
    finish_rsp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/master_bus_bridge.md
Name: master_bus_bridge

Overview:
Initiator end of the bit-serial system bus.
- Accepts a parallel read/write request from the UART-side front end.
- Shifts the address, then the write data, MSB first onto wr_bus using the master_valid/slave_ready handshake.
- For reads, collects DATA_WIDTH bits from rd_bus under the slave_valid/master_ready handshake, honouring split.
- Returns a parallel response, or an error on timeout.

Parameters:
ADDR_WIDTH, 16, address bits serialized per transaction.
DATA_WIDTH, 8, data bits per write or read.
TIMEOUT, 255, max consecutive stall cycles before abort; 0 disables the timeout.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  front-end request valid
req_ready  out  1  high in IDLE only
req_mode  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  request address
req_wdata  in  DATA_WIDTH  write data (ignored for reads)
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  front end accepts response
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
rsp_err  out  1  1 = transaction aborted by timeout
mode  out  1  bus mode, stable for the whole transaction
wr_bus  out  1  serial address/write-data line
master_valid  out  1  master driving wr_bus
master_ready  out  1  master accepting rd_bus bits
slave_ready  in  1  slave sampling wr_bus this cycle
slave_valid  in  1  slave driving rd_bus this cycle
rd_bus  in  1  serial read-data line
split  in  1  slave has split the read
split_seen  out  1  sticky per transaction: split observed

Behaviour:
- Reset (rst=1 at an edge): state IDLE.
  - master_valid, master_ready, wr_bus, mode, rsp_valid, rsp_err, split_seen, rsp_rdata, bit counter and timeout counter all go to 0.
  - req_ready reads 1 after reset.
  - Reset mid-transfer aborts silently; no response is issued.
- States: IDLE, ADDR, WDATA, RDATA, SPLIT, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch addr/wdata shift registers and mode; clear rsp_rdata, rsp_err, split_seen; go to ADDR.
- ADDR:
  - master_valid=1; wr_bus = current address MSB.
  - Each edge with slave_ready=1 shifts one bit and increments the bit count.
  - slave_ready=0 holds the current bit. The first bit is therefore held through the slave's idle-to-receive cycle.
  - After the ADDR_WIDTH-th accepted bit: mode=1 goes to WDATA, mode=0 goes to RDATA.
  - master_valid stays high continuously from ADDR through the end of WDATA and never drops mid-burst.
- WDATA: same shifting rule for DATA_WIDTH bits; then master_valid=0 and go to DONE with rsp_err=0, rsp_rdata=0.
- RDATA:
  - master_valid=0, master_ready=1.
  - Each edge with slave_valid=1 shifts rd_bus into the LSB of rdata (MSB arrives first) and increments the count.
  - After the DATA_WIDTH-th bit go to DONE, rdata = assembled word.
  - split=1 with no bit yet received goes to SPLIT.
- SPLIT:
  - master_ready stays 1; split_seen=1; timeout suspended.
  - slave_valid=1 samples the bit and goes to RDATA with count=1.
- DONE:
  - rsp_valid=1, master_valid=0, master_ready=0.
  - Stays until rsp_ready=1, then goes to IDLE. rsp_ready=0 holds indefinitely.
- Timeout counter:
  - Increments on each stall cycle in ADDR/WDATA (slave_ready=0) and RDATA (slave_valid=0). Resets on any accepted bit.
  - Reaching TIMEOUT goes to DONE with rsp_err=1, rsp_rdata=0, and handshake outputs dropped.
- Bit counter width: $clog2(max(ADDR_WIDTH,DATA_WIDTH)+1). Cleared on every phase entry.
- req_valid outside IDLE is ignored; there is no queuing.
- Throughput: an unstalled write occupies 1+ADDR_WIDTH+DATA_WIDTH bus cycles after the slave's first-ready cycle.

Test Plan:
- Write addr=0x1234 data=0xA5, slave ready 1 cycle after master_valid -> wr_bus emits 0001001000110100 then 10100101; mode=1 throughout; rsp_valid with rsp_err=0, rsp_rdata=0.
- Read addr=0x00F0; slave_valid rises 3 cycles after address ends, driving 0x3C MSB first -> rsp_rdata=0x3C, split_seen=0, master_valid low during RDATA.
- Read; split=1 for 40 cycles (exceeding TIMEOUT=16); then slave_valid returns 0x81 -> no timeout, split_seen=1, rsp_rdata=0x81, rsp_err=0.
- TIMEOUT=16 write; slave_ready held 0 after 5 address bits -> after 16 stall cycles rsp_valid=1, rsp_err=1; master_valid=0 the same cycle.
- rsp_ready held 0 for 10 cycles in DONE; req_valid pulsed meanwhile -> rsp_valid held, request ignored, req_ready=0 until rsp_ready.
- rst asserted mid-ADDR (bit 7) -> next edge all outputs 0, req_ready=1, no rsp_valid; a fresh write then completes correctly.
